// File: rtl/fp_pkg.sv
// Shared widths, constants and the FIFO entry layout for the FP adder output stage.
package fp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 24;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned FLAG_W = 3;

    localparam logic [EXP_W-1:0]  EXP_MAX        = 8'hFF;
    localparam logic [WORD_W-1:0] POS_ZERO       = 32'h0;
    localparam logic [30:0]       MAX_FINITE_MAG = 31'h7F7F_FFFF;

    localparam int unsigned ZERO = 0;
    localparam int unsigned OVF  = 1;
    localparam int unsigned UNF  = 2;

    typedef struct packed {
        logic [FLAG_W-1:0] flags;
        logic [WORD_W-1:0] word;
    } pack_entry_t;

endpackage

// File: rtl/fp_pack_fifo.sv
// Generic DEPTH x W synchronous FIFO with valid/ready on both sides.
module fp_pack_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 35
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Ready depends only on reset and occupancy, never on pop_ready.
    assign push_ready = rst && (count < FULL_CNT);
    assign pop_valid  = (count != '0);
    assign pop_data   = mem[rd_ptr];
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;

    // Storage is cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/fp_result_packer.sv
// Packs unpacked adder results into IEEE-754 single words and buffers them.
// Build option: FP_PACK_SATURATE_EN saturates overflow to the largest finite value.
module fp_result_packer
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              s_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W-1:0] mant_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] result,
    output logic              flag_zero,
    output logic              flag_ovf,
    output logic              flag_unf
);

    pack_entry_t packed_in;
    pack_entry_t head;

    // Classification in priority order: zero, overflow, unnormalized, normal.
    always_comb begin
        packed_in.word  = POS_ZERO;
        packed_in.flags = '0;
        if (mant_in == '0) begin
            packed_in.flags[ZERO] = 1'b1;
        end else if (exp_in == EXP_MAX) begin
`ifdef FP_PACK_SATURATE_EN
            packed_in.word = {s_in, MAX_FINITE_MAG};
`else
            packed_in.word = {s_in, EXP_MAX, {(MANT_W-1){1'b0}}};
`endif
            packed_in.flags[OVF] = 1'b1;
        end else if (!mant_in[MANT_W-1]) begin
            packed_in.word       = {s_in, {(WORD_W-1){1'b0}}};
            packed_in.flags[UNF] = 1'b1;
        end else begin
            packed_in.word = {s_in, exp_in, mant_in[MANT_W-2:0]};
        end
    end

    fp_pack_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(pack_entry_t))
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (packed_in),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (head)
    );

    assign result    = head.word;
    assign flag_zero = head.flags[ZERO];
    assign flag_ovf  = head.flags[OVF];
    assign flag_unf  = head.flags[UNF];

endmodule

// File: tb/tb_fp_result_packer.sv
// Randomized and directed bench for fp_result_packer against a queue-based reference.
module tb_fp_result_packer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        s_in;
    logic [7:0]  exp_in;
    logic [23:0] mant_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_zero;
    logic        flag_ovf;
    logic        flag_unf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [34:0] q[$];
    bit          clean;

`ifdef FP_PACK_SATURATE_EN
    localparam logic [31:0] NEG_OVF_WORD = 32'hFF7F_FFFF;
`else
    localparam logic [31:0] NEG_OVF_WORD = 32'hFF80_0000;
`endif

    fp_result_packer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s_in      (s_in),
        .exp_in    (exp_in),
        .mant_in   (mant_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_zero (flag_zero),
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: {unf, ovf, zero, word} straight from the IEEE packing rules.
    function automatic logic [34:0] ref_pack(input logic s, input logic [7:0] e, input logic [23:0] m);
        if (m == 24'd0)   return {3'b001, 32'h0000_0000};
        if (e == 8'd255) begin
`ifdef FP_PACK_SATURATE_EN
            return {3'b010, s, 8'd254, 23'h7F_FFFF};
`else
            return {3'b010, s, 8'd255, 23'd0};
`endif
        end
        if (m < 24'h80_0000) return {3'b100, s, 31'd0};
        return {3'b000, s, e, m[22:0]};
    endfunction

    // One clock: drive inputs, check ready, clock, update model, check head.
    task automatic step(input logic v, input logic s, input logic [7:0] e, input logic [23:0] m,
                        input logic ordy, input logic rstv);
        bit acc, pop;
        in_valid = v; s_in = s; exp_in = e; mant_in = m; out_ready = ordy; rst = rstv;
        #1;
        check_eq("in_ready", 64'(in_ready), 64'(rstv && (q.size() < DEPTH)));
        acc = rstv && v && (q.size() < DEPTH);
        pop = rstv && ordy && (q.size() != 0);
        @(posedge clk);
        #1;
        if (!rstv) begin
            q.delete();
            clean = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(ref_pack(s, e, m));
                clean = 1'b0;
            end
        end
        check_eq("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0)
            check_eq("head", 64'({flag_unf, flag_ovf, flag_zero, result}), 64'(q[0]));
        else if (clean)
            check_eq("reset_head", 64'({flag_unf, flag_ovf, flag_zero, result}), 64'd0);
    endtask

    task automatic push_one(input logic s, input logic [7:0] e, input logic [23:0] m);
        step(1'b1, s, e, m, 1'b0, 1'b1);
    endtask

    task automatic drain_one();
        step(1'b0, 1'b0, 8'd0, 24'd0, 1'b1, 1'b1);
    endtask

    initial begin
        clean = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd0, 24'd0, 1'b0, 1'b0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);

        push_one(1'b0, 8'h7F, 24'h80_0000);
        check_eq("one_word", 64'(result), 64'h3F80_0000);
        check_eq("one_flags", 64'({flag_unf, flag_ovf, flag_zero}), 64'd0);
        drain_one();

        push_one(1'b1, 8'h12, 24'h00_0000);
        check_eq("zero_word", 64'(result), 64'h0);
        check_eq("zero_flag", 64'(flag_zero), 64'd1);
        drain_one();

        push_one(1'b0, 8'h80, 24'h40_0001);
        check_eq("unf_word", 64'(result), 64'h0);
        check_eq("unf_flag", 64'(flag_unf), 64'd1);
        drain_one();

        push_one(1'b1, 8'hFF, 24'hC0_0000);
        check_eq("ovf_word", 64'(result), 64'(NEG_OVF_WORD));
        check_eq("ovf_flag", 64'(flag_ovf), 64'd1);
        drain_one();

        // Fill, attempt a third push while full, then drain in order.
        push_one(1'b0, 8'h81, 24'hA0_0000);
        push_one(1'b1, 8'h82, 24'hB0_0000);
        check_eq("full_ready", 64'(in_ready), 64'd0);
        push_one(1'b0, 8'h83, 24'hC0_0000);
        drain_one();
        check_eq("second_head", 64'(result), 64'hC130_0000);
        drain_one();
        drain_one();

        // Streaming: one in and one out every cycle.
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'($urandom), 8'($urandom_range(1, 254)), {1'b1, 23'($urandom)}, 1'b1, 1'b1);
        drain_one();

        // Reset with words buffered discards them and wins over push/pop.
        push_one(1'b0, 8'h90, 24'hFF_FFFF);
        push_one(1'b1, 8'h91, 24'h80_0001);
        step(1'b1, 1'b0, 8'h92, 24'h80_0000, 1'b1, 1'b0);
        check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_result", 64'(result), 64'd0);
        step(1'b0, 1'b0, 8'd0, 24'd0, 1'b0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            logic [7:0]  e;
            logic [23:0] m;
            e = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            case ($urandom_range(0, 7))
                0:       m = 24'd0;
                1:       m = {1'b0, 23'($urandom)};
                default: m = {1'b1, 23'($urandom)};
            endcase
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), e, m,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_result_packer.md
# fp_result_packer

Output stage of the floating-point adder: consumes the unpacked result (sign, 8-bit exponent, 24-bit mantissa with explicit leading bit) once the adder controller finishes. It packs the result into an IEEE-754 single-precision word and classifies zero, overflow and underflow. Packed words are buffered in a small FIFO with a valid/ready handshake, so the adder can start the next operation before the consumer drains the previous result.

## Interface
Parameters:
- DEPTH, 2, FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  adder result valid (controller done pulse or level)
- in_ready  out  1  packer can accept a result this cycle
- s_in  in  1  result sign
- exp_in  in  8  result exponent, biased
- mant_in  in  24  result mantissa, bit 23 = leading (hidden) bit
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head this cycle
- result  out  32  packed word at FIFO head
- flag_zero  out  1  head is a zero result
- flag_ovf  out  1  head overflowed
- flag_unf  out  1  head was an unnormalized nonzero, flushed to zero

## Operation
- Accept: in_valid && in_ready at a rising edge. Pack the word combinationally from the inputs and write it, with its 3 flags, into FIFO entry wr_ptr.
- Pack rules, evaluated in priority order:
  - mant_in == 0 → 32'h0000_0000, flag_zero=1. Sign is dropped; zero is always positive.
  - exp_in == 8'hFF → {s_in, 8'hFF, 23'b0} (infinity), flag_ovf=1.
  - mant_in[23] == 0 → {s_in, 31'b0}, flag_unf=1. No denormal support.
  - Otherwise → {s_in, exp_in, mant_in[22:0]}, all flags 0.
- FIFO: wr_ptr, rd_ptr and count (width clog2(DEPTH)+1). Pointers wrap modulo DEPTH.
- Handshake:
  - in_ready = rst && (count < DEPTH).
  - out_valid = (count != 0).
  - No combinational path from out_ready to in_ready.
- Pop: out_valid && out_ready advances rd_ptr.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full: in_ready=0. in_valid while full is ignored; the adder controller must hold its result.
- Empty: out_ready is ignored. result and flags hold their last value and are don't-care.
- Holding: result and flags are stable while out_valid && !out_ready.

## Timing
- Latency: a word accepted at edge N is visible on result/out_valid in the cycle after N.
- Throughput: 1 word per cycle while the consumer keeps out_ready high.
- Reset (rst low at an edge): count=0, pointers=0, out_valid=0, result=0, all flags=0.
  - in_ready=0 while rst is low; in_ready=1 on the first cycle after rst goes high.
  - Reset mid-stream discards all buffered words.
- Reset wins over simultaneous push/pop.

## Configuration
- FP_PACK_SATURATE_EN:
  - Defined: the exp_in == 8'hFF case packs {s_in, 8'hFE, 23'h7FFFFF} (largest finite magnitude); flag_ovf is still 1.
  - Undefined: packs signed infinity as above.
- All other behaviour is identical in both builds.

## Structure
- Shared package fp_pkg holds:
  - EXP_W=8, MANT_W=24, WORD_W=32
  - EXP_MAX=8'hFF
  - POS_ZERO=32'h0
  - MAX_FINITE_MAG=31'h7F7F_FFFF
  - flag bit indices ZERO=0, OVF=1, UNF=2
- One sub-module, fp_pack_fifo: generic DEPTH × (WORD_W+3) synchronous FIFO with valid/ready. The packing logic stays in fp_result_packer.

## Test plan
- Reset, then push s=0, exp=8'h7F, mant=24'h800000 → next cycle out_valid=1, result=32'h3F80_0000, all flags 0.
- Push mant=0, s=1 → result=32'h0000_0000, flag_zero=1. Push s=0, exp=8'h80, mant=24'h400001 → result=32'h0000_0000, flag_unf=1.
- Push s=1, exp=8'hFF, mant=24'hC00000 → result=32'hFF80_0000, flag_ovf=1. With FP_PACK_SATURATE_EN defined → result=32'hFF7F_FFFF, flag_ovf=1.
- out_ready=0, push 2 words (DEPTH=2) → in_ready=0 after the 2nd; a 3rd in_valid is ignored. Raise out_ready → words drain in order, in_ready returns to 1 the cycle after the first pop.
- Continuous in_valid and out_ready for 8 words → one word out per cycle, count stays at 1, order preserved.
- Assert rst low with 2 words buffered → next cycle out_valid=0, result=0, flags 0, in_ready=0. Release rst → in_ready=1.
